// File: rtl/led_shift_pattern_pkg.sv
// Shared encodings for the LED pattern generator.
// Mode, scan direction and fill-phase types.
package led_shift_pkg;

    typedef enum logic [1:0] {
        MODE_ROL  = 2'b00,
        MODE_ROR  = 2'b01,
        MODE_PONG = 2'b10,
        MODE_FILL = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_CLEAR = 1'b1
    } phase_e;

endpackage

// File: rtl/led_shift_pattern_if.sv
// Control/status bundle between the board logic and the pattern block.
// Master drives controls, slave drives the LED bank and tick strobe.
interface led_shift_pattern_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tick_o;

    modport master (
        output en, mode, load, load_val,
        input  out, tick_o
    );

    modport slave (
        input  en, mode, load, load_val,
        output out, tick_o
    );
endinterface

// File: rtl/led_shift_pattern_tick_divider.sv
// Prescaler: pulses step on the DIV-th enabled clock.
// clr restarts the count; en=0 freezes it.
module tick_divider #(
    parameter int DIV = 25_000_000
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic step
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign step = en && (cnt == LAST);

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_shift_pattern.sv
// LED pattern generator: rotate, ping-pong and fill/clear bar modes,
// stepped by an internal prescaler, with load and tick strobe.
module led_shift_pattern
    import led_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 25_000_000
) (
    input logic               clk_50M,
    input logic               reset,
    led_shift_pattern_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] out_q;
    logic             tick_q;
    dir_e             dir_q;
    phase_e           ph_q;
    mode_e            mode_q;
    mode_e            mode_in;
    logic             step;

    assign mode_in    = mode_e'(bus.mode);
    assign bus.out    = out_q;
    assign bus.tick_o = tick_q;

    tick_divider #(
        .DIV(DIV)
    ) u_div (
        .clk_50M(clk_50M),
        .reset  (reset),
        .en     (bus.en),
        .clr    (bus.load),
        .step   (step)
    );

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            out_q  <= ONE;
            tick_q <= 1'b0;
            dir_q  <= DIR_LEFT;
            ph_q   <= PH_FILL;
            mode_q <= MODE_ROL;
        end else begin
            tick_q <= 1'b0;
            if (bus.load) begin
                out_q <= bus.load_val;
            end else if (step) begin
                tick_q <= 1'b1;
                // A new mode restarts the pattern instead of stepping.
                if (mode_in != mode_q) begin
                    out_q  <= ONE;
                    dir_q  <= DIR_LEFT;
                    ph_q   <= PH_FILL;
                    mode_q <= mode_in;
                end else begin
                    unique case (mode_q)
                        MODE_ROL: begin
                            out_q <= {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                        end
                        MODE_ROR: begin
                            out_q <= {out_q[0], out_q[WIDTH-1:1]};
                        end
                        MODE_PONG: begin
                            unique case (1'b1)
                                (dir_q == DIR_LEFT && out_q[WIDTH-1]): begin
                                    dir_q <= DIR_RIGHT;
                                    out_q <= out_q >> 1;
                                end
                                (dir_q == DIR_RIGHT && out_q[0]): begin
                                    dir_q <= DIR_LEFT;
                                    out_q <= out_q << 1;
                                end
                                default: begin
                                    out_q <= (dir_q == DIR_LEFT) ?
                                             out_q << 1 : out_q >> 1;
                                end
                            endcase
                        end
                        MODE_FILL: begin
                            unique case (1'b1)
                                (ph_q == PH_FILL && &out_q): begin
                                    ph_q  <= PH_CLEAR;
                                    out_q <= {out_q[WIDTH-2:0], 1'b0};
                                end
                                (ph_q == PH_FILL && !(&out_q)): begin
                                    out_q <= {out_q[WIDTH-2:0], 1'b1};
                                end
                                (ph_q == PH_CLEAR && out_q == '0): begin
                                    ph_q  <= PH_FILL;
                                    out_q <= {out_q[WIDTH-2:0], 1'b1};
                                end
                                default: begin
                                    out_q <= {out_q[WIDTH-2:0], 1'b0};
                                end
                            endcase
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_led_shift_pattern.sv
// Directed bench for led_shift_pattern (WIDTH=8, DIV=4) with a
// behavioural model compared every cycle plus literal checkpoints.
module tb_led_shift_pattern;
    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int MSK = (1 << W) - 1;

    logic clk_50M;
    logic reset;

    led_shift_pattern_if #(.WIDTH(W)) bus ();

    led_shift_pattern #(
        .WIDTH(W),
        .DIV  (DIV)
    ) dut (
        .clk_50M(clk_50M),
        .reset  (reset),
        .bus    (bus.slave)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    int errors = 0;
    int checks = 0;

    // model state: pattern, 0=left/1=right, 0=fill/1=clear, mode, count
    int m_out, m_dir, m_ph, m_mode, m_cnt, m_tick;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out  = 1;
        m_dir  = 0;
        m_ph   = 0;
        m_mode = 0;
        m_cnt  = 0;
        m_tick = 0;
    endtask

    task automatic model_pattern();
        case (m_mode)
            0: m_out = ((m_out * 2) % (MSK + 1)) + (m_out / (1 << (W - 1)));
            1: m_out = (m_out / 2) + ((m_out % 2) * (1 << (W - 1)));
            2: begin
                if (m_dir == 0 && m_out >= (1 << (W - 1))) m_dir = 1;
                else if (m_dir == 1 && (m_out % 2) == 1) m_dir = 0;
                m_out = (m_dir == 0) ? (m_out * 2) % (MSK + 1) : m_out / 2;
            end
            default: begin
                if (m_ph == 0 && m_out == MSK) m_ph = 1;
                else if (m_ph == 1 && m_out == 0) m_ph = 0;
                m_out = (m_out * 2 + (m_ph == 0 ? 1 : 0)) % (MSK + 1);
            end
        endcase
    endtask

    task automatic model_clock();
        m_tick = 0;
        if (bus.load) begin
            m_out = int'(bus.load_val);
            m_cnt = 0;
        end else if (bus.en) begin
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt  = 0;
                m_tick = 1;
                if (int'(bus.mode) != m_mode) begin
                    m_mode = int'(bus.mode);
                    m_out  = 1;
                    m_dir  = 0;
                    m_ph   = 0;
                end else begin
                    model_pattern();
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            model_clock();
            @(negedge clk_50M);
            chk("out", int'(bus.out), m_out);
            chk("tick_o", int'(bus.tick_o), m_tick);
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.en       = 1'b0;
        bus.mode     = 2'b00;
        bus.load     = 1'b0;
        bus.load_val = '0;
        model_reset();
        repeat (3) @(negedge clk_50M);
        chk("reset_out", int'(bus.out), 'h01);
        chk("reset_tick", int'(bus.tick_o), 0);
        reset  = 1'b1;
        bus.en = 1'b1;

        // rotate left
        run(3);
        chk("rol_pre", int'(bus.out), 'h01);
        run(1);
        chk("rol_first", int'(bus.out), 'h02);
        chk("rol_first_tick", int'(bus.tick_o), 1);
        run(24);
        chk("rol_7", int'(bus.out), 'h80);
        run(4);
        chk("rol_8", int'(bus.out), 'h01);

        // switch to rotate right mid-run
        bus.mode = 2'b01;
        run(4);
        chk("ror_change", int'(bus.out), 'h01);
        run(4);
        chk("ror_1", int'(bus.out), 'h80);
        run(4);
        chk("ror_2", int'(bus.out), 'h40);

        // ping-pong
        bus.mode = 2'b10;
        run(4);
        chk("pong_change", int'(bus.out), 'h01);
        run(28);
        chk("pong_top", int'(bus.out), 'h80);
        run(4);
        chk("pong_back", int'(bus.out), 'h40);
        run(24);
        chk("pong_bottom", int'(bus.out), 'h01);
        run(4);
        chk("pong_up", int'(bus.out), 'h02);

        // fill/clear
        bus.mode = 2'b11;
        run(4);
        chk("fill_change", int'(bus.out), 'h01);
        run(28);
        chk("fill_full", int'(bus.out), 'hFF);
        run(4);
        chk("clear_1", int'(bus.out), 'hFE);
        run(28);
        chk("clear_empty", int'(bus.out), 'h00);
        run(4);
        chk("fill_wrap", int'(bus.out), 'h01);

        // load mid-count in rotate-left
        bus.mode = 2'b00;
        run(8);
        chk("rol_again", int'(bus.out), 'h02);
        run(2);
        bus.load     = 1'b1;
        bus.load_val = 8'h81;
        run(1);
        bus.load = 1'b0;
        chk("load_val", int'(bus.out), 'h81);
        chk("load_tick", int'(bus.tick_o), 0);
        run(3);
        chk("load_hold", int'(bus.out), 'h81);
        run(1);
        chk("load_step", int'(bus.out), 'h03);

        // zero pattern in ping-pong stays zero
        bus.mode = 2'b10;
        run(4);
        bus.load     = 1'b1;
        bus.load_val = 8'h00;
        run(1);
        bus.load = 1'b0;
        run(12);
        chk("pong_zero", int'(bus.out), 'h00);

        // freeze with en=0
        bus.load     = 1'b1;
        bus.load_val = 8'h10;
        run(1);
        bus.load = 1'b0;
        run(6);
        chk("pre_freeze", int'(bus.out), 'h20);
        bus.en = 1'b0;
        run(10);
        chk("frozen", int'(bus.out), 'h20);
        bus.en = 1'b1;
        run(2);
        chk("thaw_step", int'(bus.out), 'h40);
        chk("thaw_tick", int'(bus.tick_o), 1);
        run(1);

        // asynchronous reset between edges
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("async_out", int'(bus.out), 'h01);
        chk("async_tick", int'(bus.tick_o), 0);
        @(negedge clk_50M);
        reset = 1'b1;
        run(4);
        chk("post_reset_change", int'(bus.out), 'h01);
        run(4);
        chk("post_reset_pong", int'(bus.out), 'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
